// File: rtl/project_pkg.sv
// Shared types for the AXI-Stream frame checker: verdict codes, FSM states, default limits.
package project_pkg;

  localparam int unsigned MAX_LEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_OK,
    ST_ERR_LEN,
    ST_ERR_SHORT,
    ST_ERR_LONG,
    ST_ERR_CHK
  } stat_e;

  typedef enum logic [2:0] {
    S_LEN,
    S_PAY,
    S_CHK,
    S_DROP,
    S_STAT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/axis_frame_checker.sv
// Checks length/payload/XOR-checksum framing on an 8-bit AXI-Stream and reports one verdict
// per frame through a valid/ready status port, with saturating good/bad frame counters.
module axis_frame_checker
  import project_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic             stat_valid,
  input  logic             stat_ready,
  output stat_e            stat_code,
  output logic [7:0]       stat_len,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  state_e     state_q;
  stat_e      code_q;
  logic [7:0] len_q;
  logic [7:0] acc_q;
  logic [7:0] cnt_q;
  logic       accept;
  logic       stat_hs;

  // Ready is held low while reset is asserted, not only after it is sampled.
  assign s_axis_tready = (state_q != S_STAT) && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign stat_valid    = (state_q == S_STAT);
  assign stat_hs       = stat_valid && stat_ready;
  assign stat_code     = code_q;
  assign stat_len      = len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
      code_q  <= ST_OK;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_LEN: begin
          if (accept) begin
            len_q <= s_axis_tdata;
            acc_q <= s_axis_tdata;
            if ((s_axis_tdata == 8'd0) || (s_axis_tdata > MaxLenB)) begin
              code_q  <= ST_ERR_LEN;
              state_q <= s_axis_tlast ? S_STAT : S_DROP;
            end else if (s_axis_tlast) begin
              code_q  <= ST_ERR_SHORT;
              state_q <= S_STAT;
            end else begin
              cnt_q   <= s_axis_tdata;
              state_q <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (accept) begin
            acc_q <= acc_q ^ s_axis_tdata;
            cnt_q <= cnt_q - 8'd1;
            if (s_axis_tlast) begin
              code_q  <= ST_ERR_SHORT;
              state_q <= S_STAT;
            end else if (cnt_q == 8'd1) begin
              state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            // A missing tlast outranks a checksum mismatch.
            if (!s_axis_tlast) begin
              code_q  <= ST_ERR_LONG;
              state_q <= S_DROP;
            end else begin
              code_q  <= (s_axis_tdata == acc_q) ? ST_OK : ST_ERR_CHK;
              state_q <= S_STAT;
            end
          end
        end
        S_DROP: begin
          if (accept && s_axis_tlast) begin
            state_q <= S_STAT;
          end
        end
        S_STAT: begin
          if (stat_ready) begin
            state_q <= S_LEN;
          end
        end
        default: state_q <= S_LEN;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_ok_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stat_hs && (code_q == ST_OK)),
    .q  (ok_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stat_hs && (code_q != ST_OK)),
    .q  (err_cnt)
  );

endmodule

// File: tb/tb_axis_frame_checker.sv
// Scoreboard bench: stimulus queues expected verdicts, a monitor pops them on each stat handshake.
module tb_axis_frame_checker;
  import project_pkg::*;

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        sready = 1'b1;
  logic        tready, tready2, svalid, svalid2;
  stat_e       code, code2;
  logic [7:0]  slen, slen2;
  logic [15:0] ok1, err1;
  logic [1:0]  ok2, err2;

  exp_t        expq[$];
  exp_t        e;
  logic [7:0]  fb[$];
  int          tests = 0;
  int          fails = 0;
  int          mok1 = 0, merr1 = 0, mok2 = 0, merr2 = 0;
  bit          pend = 0;

  always #5 clk = ~clk;

  axis_frame_checker #(.MAX_LEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .stat_valid(svalid), .stat_ready(sready),
    .stat_code(code), .stat_len(slen), .ok_cnt(ok1), .err_cnt(err1)
  );

  axis_frame_checker #(.MAX_LEN(64), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready2), .s_axis_tlast(tlast), .stat_valid(svalid2), .stat_ready(sready),
    .stat_code(code2), .stat_len(slen2), .ok_cnt(ok2), .err_cnt(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: verdicts on handshake, counters one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      mok1 = 0; merr1 = 0; mok2 = 0; merr2 = 0; pend = 0;
    end else begin
      if (pend) begin
        chk("ok_cnt", 32'(ok1), 32'(mok1));
        chk("err_cnt", 32'(err1), 32'(merr1));
        chk("ok_cnt w2", 32'(ok2), 32'(mok2));
        chk("err_cnt w2", 32'(err2), 32'(merr2));
        pend = 0;
      end
      if (svalid && sready) begin
        if (expq.size() == 0) begin
          chk("unexpected verdict", 32'(code), 32'hFFFF);
        end else begin
          e = expq.pop_front();
          chk("stat_code", 32'(code), 32'(e.code));
          chk("stat_len", 32'(slen), 32'(e.len));
          chk("stat_code w2", 32'(code2), 32'(e.code));
          chk("stat_valid w2", 32'(svalid2), 32'd1);
          if (e.code == ST_OK) begin
            mok1++;
            if (mok2 < 3) mok2++;
          end else begin
            merr1++;
            if (merr2 < 3) merr2++;
          end
          pend = 1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit last, output bit stalled);
    int n;
    n = 0;
    stalled = 0;
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tlast = last;
    while (!tready && n < 50) begin
      stalled = 1; n++;
      @(negedge clk);
    end
    if (!tready) chk("tready timeout", 32'(tready), 32'd1);
    @(posedge clk);
  endtask

  // Sends fb as one frame; gap_at inserts idle cycles before that byte index.
  task automatic send_frame(input stat_e c, input logic [7:0] l, input int gap_at);
    bit st;
    int stalls;
    stalls = 0;
    expq.push_back('{code: c, len: l});
    for (int i = 0; i < fb.size(); i++) begin
      if (i == gap_at) begin
        @(negedge clk);
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
      end
      send_byte(fb[i], i == fb.size() - 1, st);
      if (i > 0 && st) stalls++;
    end
    #1;
    chk("stat_valid latency", 32'(svalid), 32'd1);
    chk("no stall mid-frame", 32'(stalls), 32'd0);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst stat_valid", 32'(svalid), 32'd0);
    chk("rst tready", 32'(tready), 32'd0);
    chk("rst stat_code", 32'(code), 32'(ST_OK));
    chk("rst stat_len", 32'(slen), 32'd0);
    chk("rst ok_cnt", 32'(ok1), 32'd0);
    chk("rst err_cnt", 32'(err1), 32'd0);
  endtask

  initial begin
    stat_e      cap_code;
    logic [7:0] cap_len;
    bit         st;
    int         n;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;

    fb = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    send_frame(ST_OK, 8'd3, -1);
    fb = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h07};
    send_frame(ST_ERR_CHK, 8'd3, -1);
    fb = '{8'h05, 8'hAA, 8'hBB};
    send_frame(ST_ERR_SHORT, 8'd5, -1);
    fb = '{8'h00, 8'hFF};
    send_frame(ST_ERR_LEN, 8'd0, -1);
    fb = '{8'h01, 8'h10, 8'h11, 8'h22, 8'h33};
    send_frame(ST_ERR_LONG, 8'd1, -1);
    fb = '{8'h41};
    send_frame(ST_ERR_LEN, 8'h41, -1);
    fb = '{8'h02};
    send_frame(ST_ERR_SHORT, 8'd2, -1);

    // Longest legal frame: XOR of 0..63 is zero, so checksum equals the length byte.
    fb = {};
    fb.push_back(8'h40);
    for (int i = 0; i < 64; i++) fb.push_back(8'(i));
    fb.push_back(8'h40);
    send_frame(ST_OK, 8'h40, -1);

    fb = '{8'h02, 8'h05, 8'h06, 8'h01};
    send_frame(ST_OK, 8'd2, 2);

    // Back-pressure on the status port.
    @(posedge clk); #1 sready = 1'b0;
    fb = '{8'h01, 8'h7E, 8'h7F};
    send_frame(ST_OK, 8'd1, -1);
    @(negedge clk);
    cap_code = code; cap_len = slen;
    repeat (5) begin
      @(negedge clk);
      chk("hold tready", 32'(tready), 32'd0);
      chk("hold tready w2", 32'(tready2), 32'd0);
      chk("hold stat_valid", 32'(svalid), 32'd1);
      chk("hold stat_code", 32'(code), 32'(cap_code));
      chk("hold stat_len", 32'(slen), 32'(cap_len));
    end
    @(posedge clk); #1 sready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset in the middle of a payload abandons the frame.
    send_byte(8'h04, 1'b0, st);
    send_byte(8'h01, 1'b0, st);
    #1 rst = 1'b1; tvalid = 1'b0;
    @(posedge clk); #1;
    chk_reset_state();
    rst = 1'b0;

    fb = '{8'h01, 8'h00, 8'h01};
    send_frame(ST_OK, 8'd1, -1);

    fb = '{8'h02, 8'h10, 8'h20, 8'h32};
    repeat (5) send_frame(ST_OK, 8'd2, -1);

    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk("queue drained", 32'(expq.size()), 32'd0);
    chk("final ok_cnt", 32'(ok1), 32'd6);
    chk("final err_cnt", 32'(err1), 32'd0);
    chk("final ok_cnt w2 saturated", 32'(ok2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_frame_checker.md
AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, maximum legal payload length in bytes (1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the frame statistics counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port s_axis_tdata, input, 8, frame byte.
REQ-006 SHALL have port s_axis_tvalid, input, 1, byte valid.
REQ-007 SHALL have port s_axis_tready, output, 1, byte accepted when tvalid&&tready.
REQ-008 SHALL have port s_axis_tlast, input, 1, last byte of frame.
REQ-009 SHALL have port stat_valid, output, 1, frame verdict available.
REQ-010 SHALL have port stat_ready, input, 1, verdict consumed when stat_valid&&stat_ready.
REQ-011 SHALL have port stat_code, output, 3, verdict, of type stat_e.
REQ-012 SHALL have port stat_len, output, 8, length byte of the judged frame.
REQ-013 SHALL have ports ok_cnt and err_cnt, output, CNT_W, saturating counts of good and bad frames.

Function
REQ-014 SHALL use this frame format: byte0 = length N; then N payload bytes; then 1 checksum byte equal to the XOR of byte0 and all payload bytes; tlast on the checksum byte.
REQ-015 SHALL run FSM states S_LEN, S_PAY, S_CHK, S_DROP, S_STAT, with reset state S_LEN.
REQ-016 In S_LEN, an accepted byte with 1<=N<=MAX_LEN and no tlast SHALL load the down-counter to N, seed the XOR accumulator with the byte, and go to S_PAY.
REQ-017 In S_LEN, N==0 or N>MAX_LEN SHALL set verdict ST_ERR_LEN and go to S_DROP, or to S_STAT if tlast is set on that byte.
REQ-018 In S_LEN, tlast on a legal length byte SHALL set verdict ST_ERR_SHORT and go to S_STAT.
REQ-019 In S_PAY, each accepted byte SHALL XOR into the accumulator and decrement the counter; after the byte that takes the counter to 0 the FSM SHALL go to S_CHK.
REQ-020 In S_PAY, tlast on any payload byte SHALL set ST_ERR_SHORT and go to S_STAT.
REQ-021 In S_CHK, the accepted byte SHALL be compared with the accumulator: on a match with tlast, ST_OK; on a mismatch with tlast, ST_ERR_CHK; in both cases go to S_STAT.
REQ-022 In S_CHK, a byte without tlast SHALL set ST_ERR_LONG and go to S_DROP; ST_ERR_LONG takes priority over a checksum mismatch.
REQ-023 S_DROP SHALL accept and discard bytes until tlast, then go to S_STAT with the verdict unchanged.
REQ-024 In S_STAT, stat_valid SHALL be 1 and s_axis_tready SHALL be 0.
REQ-025 In S_STAT, on stat_valid&&stat_ready the FSM SHALL return to S_LEN on the next cycle.
REQ-026 s_axis_tready SHALL be 1 in all states except S_STAT.
REQ-027 stat_valid SHALL assert the cycle after the deciding byte is accepted (1-cycle latency).
REQ-028 stat_code and stat_len SHALL stay stable while stat_valid&&!stat_ready.
REQ-029 ok_cnt SHALL increment by 1 on the stat handshake when stat_code==ST_OK.
REQ-030 err_cnt SHALL increment by 1 on the stat handshake for any other code.
REQ-031 ok_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 Bytes with tvalid low SHALL leave all state unchanged; gaps of any length are legal.

Reset
REQ-033 While rst=1 at a clock edge: state=S_LEN, stat_valid=0, s_axis_tready=0 during reset, stat_code=ST_OK, stat_len=0, accumulator=0, counter=0, ok_cnt=0, err_cnt=0.
REQ-034 Reset mid-frame or mid-stat SHALL abandon the frame with no counter update; the first byte after reset is treated as a length byte.

Structure
REQ-035 The enum stat_e {ST_OK, ST_ERR_LEN, ST_ERR_SHORT, ST_ERR_LONG, ST_ERR_CHK} and the default MAX_LEN constant SHALL live in project_pkg, shared with the frame generator and test classes.
REQ-036 A sub-module sat_counter (parameter W; ports clk, rst, inc, q) SHALL implement both statistics counters.

Verification
REQ-037 Frame 03,01,02,03,03 (tlast on last) -> stat_code=ST_OK, stat_len=3, ok_cnt=1.
REQ-038 Frame 03,01,02,03,07 -> ST_ERR_CHK, err_cnt=1.
REQ-039 Frame 05,AA,BB with tlast on BB -> ST_ERR_SHORT; length byte 00 followed by FF(tlast) -> ST_ERR_LEN after FF is dropped.
REQ-040 Frame 01,10,11,22,33(tlast) -> ST_ERR_LONG, tready=1 through 33, stat_valid the following cycle.
REQ-041 Hold stat_ready=0 for 5 cycles -> tready=0 and stat fields stable; then pulse rst mid-payload -> counters cleared, next frame judged fresh.
REQ-042 CNT_W=2 with 5 good frames -> ok_cnt sticks at 3.
